// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier controller: accepts an operand pair, retires
// one multiplier bit per clock, and returns the W-bit product plus an overflow flag.
module mult_seq_ctrl #(
  parameter int unsigned W          = 65,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic         ovf,
  output logic         busy
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_last;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [W-1:0]     product_q;
  logic             ovf_q;
  logic             busy_q;

  // One step of the recurrence; only consumed while in RUN.
  // NOTE: every always_comb output is assigned on every path, so no latch can form.
  always_comb begin
    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
    cnt_d    = cnt_q + 1'b1;
    run_last = (cnt_d == CW'(W)) || (EARLY_EXIT && (mplier_d == '0));
  end

  // NOTE: state updates use <= so every register samples its peers' pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are cleared too, so an aborted run leaves nothing stale.
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= {{W{1'b0}}, a};
            mplier_q   <= b;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end

        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_d;
          if (run_last) begin
            // Result is latched from the final step so out_valid and data rise together.
            product_q   <= acc_d[W-1:0];
            ovf_q       <= |acc_d[2*W-1:W];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencing controller for a shared shift-add multiplier datapath.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Runs the add-and-shift recurrence (one multiplier bit per clock), then presents the W-bit truncated product plus an overflow flag on a valid/ready result port.
- Sits between an operand producer and a result consumer. Replaces a wide combinational multiplier where area matters and operand widths exceed 32 bits.

Parameters:
- W, 65, operand and product width in bits; any value >= 2, values past 32 required to work.
- EARLY_EXIT, 0, when 1 the run ends once the remaining multiplier bits are all zero.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair a/b is present.
- in_ready  output  1  controller can accept operands.
- a  input  W  multiplicand.
- b  input  W  multiplier.
- out_valid  output  1  product/ovf valid.
- out_ready  input  1  consumer takes the result.
- product  output  W  (a*b) mod 2^W.
- ovf  output  1  1 when the full 2W-bit product exceeds 2^W-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at posedge) overrides everything, including mid-RUN or DONE:
  - state=IDLE, in_ready=1, out_valid=0, product=0, ovf=0, busy=0.
  - All internal registers are cleared. Any in-flight transaction is discarded, with no result emitted.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state only; there is no combinational path from in_valid/out_ready to any output.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a posedge: mcand={W'b0,a} (2W bits), mplier=b, acc=0 (2W bits), cnt=0, go to RUN.
- RUN (in_ready=0):
  - Each posedge: if mplier[0], acc=acc+mcand, computed mod 2^(2W). Then mcand=mcand<<1, mplier=mplier>>1, cnt=cnt+1.
  - With EARLY_EXIT=0: leave to DONE on the posedge where cnt reaches W.
  - With EARLY_EXIT=1: also leave on the posedge where the shifted mplier becomes 0.
- DONE:
  - out_valid=1, product=acc[W-1:0], ovf=|acc[2W-1:W].
  - Values are held stable while out_ready=0.
  - On out_valid&out_ready at a posedge, go to IDLE; out_valid drops the next cycle.
  - product/ovf retain their last value in IDLE.
- Latency, counted in posedges from the accept edge to the first cycle with out_valid=1:
  - EARLY_EXIT=0: exactly W.
  - EARLY_EXIT=1: max(1, msb_index(b)+1). b=0 gives 1.
- Throughput:
  - No overlap; in_ready is 0 in RUN and DONE.
  - Back-to-back minimum spacing is latency+2 cycles.
  - in_valid asserted outside IDLE is ignored; the producer must hold a/b until accepted.
- Width rules:
  - product equals the Verilog W-bit assignment of a*b.
  - Bit indices are little-endian [W-1:0] internally, regardless of how a caller declares its vectors.
- cnt is wide enough to hold W ($clog2(W+1) bits) with no wrap.
- Simultaneous out_ready and in_valid in DONE: only the result handshake completes; the operand is accepted no earlier than the following IDLE cycle.

Test Plan:
- Reset then a=1, b=1, EARLY_EXIT=0 -> out_valid exactly 65 edges after accept, product=1, ovf=0, in_ready=0 throughout RUN.
- a=b=2^65-1 -> product=1, ovf=1. With a=2^64, b=2 -> product=0, ovf=1.
- Walking-1s, walking-0s and walking-101 sweeps, 65x65 pairs with random out_ready stalls -> every product equals a*b truncated to 65 bits, and ovf matches a 130-bit reference.
- Hold out_ready=0 for 10 cycles in DONE with a=3, b=5 -> product=15 stable all 10 cycles, in_ready=0, exactly one handshake.
- EARLY_EXIT=1: b=0 -> latency 1, product=0. b=2^10 -> latency 11, product=a<<10 truncated.
- Assert rst for 1 cycle at RUN cycle 30 -> next cycle IDLE, in_ready=1, out_valid=0, product=0. The next transaction a=7, b=9 yields product=63.
